// File: rtl/minisrc_mem_pkg.sv
// Shared types and helpers for the word-addressed RAM controller and its storage array.
package minisrc_mem_pkg;

  typedef enum logic [1:0] {
    ST_CLEARING,
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } state_e;

  localparam int READ_LATENCY_MIN = 1;
  localparam int READ_LATENCY_MAX = 4;

  function automatic int lane_count(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/mem_array.sv
// Word storage: one byte-lane write port and one registered read port (1 cycle).
// Read register holds until the next enabled read; clr zeroes it.
module mem_array
  import minisrc_mem_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 9,
  parameter int MEM_SIZE      = 512
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic                      we,
  input  logic [ADDRESS_WIDTH-1:0]  waddr,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [DATA_WIDTH/8-1:0]   wbe,
  input  logic                      re,
  input  logic [ADDRESS_WIDTH-1:0]  raddr,
  input  logic                      rzero,
  output logic [DATA_WIDTH-1:0]     rdata
);

  localparam int LANES = lane_count(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] mem_q [MEM_SIZE];
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  always_ff @(posedge clk) begin
    for (int k = 0; k < LANES; k++) begin
      if (we && wbe[k]) mem_q[waddr][8*k +: 8] <= wdata[8*k +: 8];
    end
  end

  // Out-of-range reads return zero instead of indexing past the array.
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = rzero ? '0 : mem_q[raddr];
  end

  always_ff @(posedge clk) begin
    if (clr) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ram_ctrl.sv
// Level-request RAM controller: write completes next cycle, read after READ_LATENCY cycles,
// mfc held until both requests drop; busy blocks new requests, clear restarts a full zero sweep.
module ram_ctrl
  import minisrc_mem_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 9,
  parameter int MEM_SIZE      = 512,
  parameter int READ_LATENCY  = 1
) (
  input  logic                      clk,
  input  logic                      clear,
  input  logic                      read,
  input  logic                      write,
  input  logic [ADDRESS_WIDTH-1:0]  address,
  input  logic [DATA_WIDTH-1:0]     data_in,
  input  logic [DATA_WIDTH/8-1:0]   byte_en,
  output logic [DATA_WIDTH-1:0]     data_out,
  output logic                      mfc,
  output logic                      busy
);

  localparam int LAT = (READ_LATENCY < READ_LATENCY_MIN) ? READ_LATENCY_MIN :
                       (READ_LATENCY > READ_LATENCY_MAX) ? READ_LATENCY_MAX : READ_LATENCY;
  localparam int LAT_W = (LAT > 2) ? $clog2(LAT - 1) : 1;
  localparam logic [LAT_W-1:0]         LAT_LAST   = LAT_W'((LAT > 1) ? LAT - 2 : 0);
  localparam logic [ADDRESS_WIDTH-1:0] SWEEP_LAST = ADDRESS_WIDTH'(MEM_SIZE - 1);
  localparam logic [ADDRESS_WIDTH:0]   MEM_LIMIT  = (ADDRESS_WIDTH + 1)'(MEM_SIZE);

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] ptr_q, ptr_d;
  logic [LAT_W-1:0]         cnt_q, cnt_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic                     mfc_q, mfc_d;
  logic                     busy_q, busy_d;

  logic                     mem_we, mem_re, mem_rzero;
  logic [ADDRESS_WIDTH-1:0] mem_waddr, mem_raddr;
  logic [DATA_WIDTH-1:0]    mem_wdata;
  logic [DATA_WIDTH/8-1:0]  mem_wbe;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    mfc_d     = mfc_q;
    busy_d    = busy_q;
    mem_we    = 1'b0;
    mem_waddr = address;
    mem_wdata = data_in;
    mem_wbe   = byte_en;
    mem_re    = 1'b0;
    mem_raddr = addr_q;
    case (state_q)
      ST_CLEARING: begin
        mem_we    = 1'b1;
        mem_waddr = ptr_q;
        mem_wdata = '0;
        mem_wbe   = '1;
        if (ptr_q == SWEEP_LAST) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      ST_IDLE: begin
        // A write wins over a simultaneous read and lands at the accept edge.
        if (write) begin
          mem_we  = ({1'b0, address} < MEM_LIMIT);
          state_d = ST_DONE;
          mfc_d   = 1'b1;
          busy_d  = 1'b1;
        end else if (read) begin
          addr_d = address;
          busy_d = 1'b1;
          cnt_d  = '0;
          if (LAT == 1) begin
            mem_re    = 1'b1;
            mem_raddr = address;
            state_d   = ST_DONE;
            mfc_d     = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == LAT_LAST) begin
          mem_re  = 1'b1;
          state_d = ST_DONE;
          mfc_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (!read && !write) begin
          state_d = ST_IDLE;
          mfc_d   = 1'b0;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_CLEARING;
        ptr_d   = '0;
        mfc_d   = 1'b0;
        busy_d  = 1'b1;
      end
    endcase
    if (clear) begin
      mem_we = 1'b0;
      mem_re = 1'b0;
    end
  end

  assign mem_rzero = ({1'b0, mem_raddr} >= MEM_LIMIT);

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= ST_CLEARING;
      ptr_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      mfc_q   <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      mfc_q   <= mfc_d;
      busy_q  <= busy_d;
    end
  end

  mem_array #(
    .DATA_WIDTH   (DATA_WIDTH),
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .MEM_SIZE     (MEM_SIZE)
  ) u_mem (
    .clk  (clk),
    .clr  (clear),
    .we   (mem_we),
    .waddr(mem_waddr),
    .wdata(mem_wdata),
    .wbe  (mem_wbe),
    .re   (mem_re),
    .raddr(mem_raddr),
    .rzero(mem_rzero),
    .rdata(data_out)
  );

  assign mfc  = mfc_q;
  assign busy = busy_q;

endmodule
